// File: rtl/jelly_rtos_ready_queue.sv
// jelly_rtos_ready_queue
//
// Central ready queue for the RTOS task blocks. Each task block raises a
// level add request and holds it until it sees its rdy_tsk acknowledge.
// A task block can also pulse a remove request for a single cycle. The
// queue keeps a bitmap of ready tasks. It publishes the ready task with the
// numerically lowest priority as top_tskid, and ties go to the lowest ID.
//
// Ports:
//   reset      synchronous, active-high reset
//   clk        clock
//   cke        clock enable; when low, all state holds and no add is acknowledged
//   busy       high while any add request is pending (combinational)
//   rdq_add    per-task add request (level, held until acknowledged)
//   rdq_rmv    per-task remove request (single-cycle pulse)
//   tskpri     packed per-task priority, task i at [i*TSKPRI_WIDTH +: TSKPRI_WIDTH]
//   rdy_tsk    one-hot acknowledge of the add accepted this cycle (combinational)
//   rdy_bitmap registered ready bitmap
//   top_valid  registered; at least one task is ready
//   top_tskid  registered ID of the highest-priority ready task
module jelly_rtos_ready_queue #(
    parameter int                TASKS        = 16,
    parameter int                TSKID_WIDTH  = 4,
    parameter int                TSKPRI_WIDTH = 4,
    parameter logic [TASKS-1:0]  INIT_READY   = '0
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic                          cke,

    output logic                          busy,

    input  logic [TASKS-1:0]              rdq_add,
    input  logic [TASKS-1:0]              rdq_rmv,
    input  logic [TASKS*TSKPRI_WIDTH-1:0] tskpri,

    output logic [TASKS-1:0]              rdy_tsk,
    output logic [TASKS-1:0]              rdy_bitmap,
    output logic                          top_valid,
    output logic [TSKID_WIDTH-1:0]        top_tskid
);

    // The comparator tree works on a power-of-two number of leaves.
    // Any padding leaves are never valid.
    localparam int LEVELS = (TASKS > 1) ? $clog2(TASKS) : 1;
    localparam int LEAVES = 1 << LEVELS;
    localparam int NODES  = 2 * LEAVES - 1;

    logic [TASKS-1:0]        add_onehot;
    logic                    add_found;
    logic [TASKS-1:0]        next_bitmap;
    logic [TASKS-1:0]        sel_bitmap;

    logic                    node_valid [0:NODES-1];
    logic [TSKPRI_WIDTH-1:0] node_pri   [0:NODES-1];
    logic [TSKID_WIDTH-1:0]  node_id    [0:NODES-1];

    assign busy = |rdq_add;

    // Accept the lowest-indexed add whose task is not also removing this cycle.
    // A remove on the same task wins, so that task's add stays pending.
    always_comb begin
        add_onehot = '0;
        add_found  = 1'b0;
        for (int i = 0; i < TASKS; i++) begin
            if (!add_found && rdq_add[i] && !rdq_rmv[i]) begin
                add_onehot[i] = 1'b1;
                add_found     = 1'b1;
            end
        end
    end

    // No acknowledge is issued during reset or while the clock enable is low.
    // This keeps the task from dropping an add request that the bitmap never recorded.
    assign rdy_tsk = (cke && !reset) ? add_onehot : '0;

    assign next_bitmap = (rdy_bitmap | rdy_tsk) & ~rdq_rmv;

    // The selection runs over the bitmap that is about to be registered. This way
    // top_* always match rdy_bitmap in the same cycle. During reset the tree
    // looks at INIT_READY instead, so top_* come out of reset consistent with it.
    assign sel_bitmap = reset ? INIT_READY : next_bitmap;

    // Balanced minimum tree. Leaves sit at nodes LEAVES-1 .. NODES-1 in task
    // order, and node k merges children 2k+1 (lower IDs) and 2k+2. The left
    // child wins on equal priority, so ties resolve to the lowest task ID.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            node_valid[n] = 1'b0;
            node_pri[n]   = '0;
            node_id[n]    = '0;
        end
        for (int i = 0; i < LEAVES; i++) begin
            if (i < TASKS) begin
                node_valid[LEAVES-1+i] = sel_bitmap[i];
                node_pri[LEAVES-1+i]   = tskpri[i*TSKPRI_WIDTH +: TSKPRI_WIDTH];
                node_id[LEAVES-1+i]    = TSKID_WIDTH'(i);
            end
        end
        for (int k = LEAVES - 2; k >= 0; k--) begin
            if (node_valid[2*k+1] &&
                (!node_valid[2*k+2] || (node_pri[2*k+1] <= node_pri[2*k+2]))) begin
                node_valid[k] = 1'b1;
                node_pri[k]   = node_pri[2*k+1];
                node_id[k]    = node_id[2*k+1];
            end
            else begin
                node_valid[k] = node_valid[2*k+2];
                node_pri[k]   = node_pri[2*k+2];
                node_id[k]    = node_id[2*k+2];
            end
        end
    end

    // Bitmap and selection registers. With nothing ready, top_tskid keeps the
    // last winner so the dispatcher's run_tskid does not glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_bitmap <= INIT_READY;
            top_valid  <= node_valid[0];
            top_tskid  <= node_valid[0] ? node_id[0] : '0;
        end
        else if (cke) begin
            rdy_bitmap <= next_bitmap;
            top_valid  <= node_valid[0];
            if (node_valid[0]) begin
                top_tskid <= node_id[0];
            end
        end
    end

endmodule

// File: tb/tb_jelly_rtos_ready_queue.sv
// tb_jelly_rtos_ready_queue
//
// Directed testbench for jelly_rtos_ready_queue with 16 tasks and 4-bit
// priorities. Each scenario task drives the inputs one cycle at a time and
// checks the outputs against hand-computed values. Inputs change 1ns after
// the rising edge, and outputs are checked a further 1ns later.
module tb_jelly_rtos_ready_queue;

    localparam int TASKS        = 16;
    localparam int TSKID_WIDTH  = 4;
    localparam int TSKPRI_WIDTH = 4;

    logic                          reset;
    logic                          clk;
    logic                          cke;
    logic                          busy;
    logic [TASKS-1:0]              rdq_add;
    logic [TASKS-1:0]              rdq_rmv;
    logic [TASKS*TSKPRI_WIDTH-1:0] tskpri;
    logic [TASKS-1:0]              rdy_tsk;
    logic [TASKS-1:0]              rdy_bitmap;
    logic                          top_valid;
    logic [TSKID_WIDTH-1:0]        top_tskid;

    int checks   = 0;
    int failures = 0;

    jelly_rtos_ready_queue #(
        .TASKS        (TASKS),
        .TSKID_WIDTH  (TSKID_WIDTH),
        .TSKPRI_WIDTH (TSKPRI_WIDTH),
        .INIT_READY   (16'h0000)
    ) dut (
        .reset      (reset),
        .clk        (clk),
        .cke        (cke),
        .busy       (busy),
        .rdq_add    (rdq_add),
        .rdq_rmv    (rdq_rmv),
        .tskpri     (tskpri),
        .rdy_tsk    (rdy_tsk),
        .rdy_bitmap (rdy_bitmap),
        .top_valid  (top_valid),
        .top_tskid  (top_tskid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pri(input int idx, input logic [TSKPRI_WIDTH-1:0] pri);
        tskpri[idx*TSKPRI_WIDTH +: TSKPRI_WIDTH] = pri;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        cke     = 1'b1;
        rdq_add = '0;
        rdq_rmv = '0;
        for (int i = 0; i < TASKS; i++) set_pri(i, TSKPRI_WIDTH'(i));
        tick();
        tick();
        #1;
        checks++; if (rdy_bitmap !== 16'h0000) begin failures++; $display("[TB] FAIL reset_bitmap: got %h expected %h", rdy_bitmap, 16'h0000); end
        checks++; if (top_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_top_valid: got %b expected 0", top_valid); end
        checks++; if (top_tskid !== 4'd0) begin failures++; $display("[TB] FAIL reset_top_tskid: got %0d expected 0", top_tskid); end
        checks++; if (rdy_tsk !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rdy_tsk: got %h expected %h", rdy_tsk, 16'h0000); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_add();
        rdq_add = 16'h0020;
        #1;
        checks++; if (rdy_tsk !== 16'h0020) begin failures++; $display("[TB] FAIL single_ack: got %h expected %h", rdy_tsk, 16'h0020); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        tick();
        rdq_add = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0020) begin failures++; $display("[TB] FAIL single_bitmap: got %h expected %h", rdy_bitmap, 16'h0020); end
        checks++; if (top_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_top_valid: got %b expected 1", top_valid); end
        checks++; if (top_tskid !== 4'd5) begin failures++; $display("[TB] FAIL single_top_tskid: got %0d expected 5", top_tskid); end
        checks++; if (rdy_tsk !== 16'h0000) begin failures++; $display("[TB] FAIL single_no_reack: got %h expected %h", rdy_tsk, 16'h0000); end
        // Empty the queue again. top_tskid keeps 5.
        rdq_rmv = 16'h0020;
        tick();
        rdq_rmv = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0000) begin failures++; $display("[TB] FAIL single_cleanup_bitmap: got %h expected %h", rdy_bitmap, 16'h0000); end
        checks++; if (top_tskid !== 4'd5) begin failures++; $display("[TB] FAIL single_cleanup_hold_id: got %0d expected 5", top_tskid); end
    endtask

    task automatic test_back_to_back();
        rdq_add = 16'h0208;
        #1;
        checks++; if (rdy_tsk !== 16'h0008) begin failures++; $display("[TB] FAIL b2b_ack0: got %h expected %h", rdy_tsk, 16'h0008); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy0: got %b expected 1", busy); end
        tick();
        rdq_add = 16'h0200;
        #1;
        checks++; if (rdy_tsk !== 16'h0200) begin failures++; $display("[TB] FAIL b2b_ack1: got %h expected %h", rdy_tsk, 16'h0200); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy1: got %b expected 1", busy); end
        checks++; if (rdy_bitmap !== 16'h0008) begin failures++; $display("[TB] FAIL b2b_bitmap1: got %h expected %h", rdy_bitmap, 16'h0008); end
        checks++; if (top_tskid !== 4'd3) begin failures++; $display("[TB] FAIL b2b_top1: got %0d expected 3", top_tskid); end
        tick();
        rdq_add = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy2: got %b expected 0", busy); end
        checks++; if (rdy_bitmap !== 16'h0208) begin failures++; $display("[TB] FAIL b2b_bitmap2: got %h expected %h", rdy_bitmap, 16'h0208); end
        checks++; if (top_tskid !== 4'd3) begin failures++; $display("[TB] FAIL b2b_top2: got %0d expected 3", top_tskid); end
        checks++; if (top_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid2: got %b expected 1", top_valid); end
    endtask

    task automatic test_remove();
        // Add task 5 and remove task 9 on the same edge. Tasks 3 and 5 are then ready.
        rdq_add = 16'h0020;
        rdq_rmv = 16'h0200;
        #1;
        checks++; if (rdy_tsk !== 16'h0020) begin failures++; $display("[TB] FAIL rmv_mixed_ack: got %h expected %h", rdy_tsk, 16'h0020); end
        tick();
        rdq_add = '0;
        rdq_rmv = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0028) begin failures++; $display("[TB] FAIL rmv_mixed_bitmap: got %h expected %h", rdy_bitmap, 16'h0028); end
        checks++; if (top_tskid !== 4'd3) begin failures++; $display("[TB] FAIL rmv_mixed_top: got %0d expected 3", top_tskid); end
        rdq_rmv = 16'h0008;
        tick();
        rdq_rmv = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0020) begin failures++; $display("[TB] FAIL rmv3_bitmap: got %h expected %h", rdy_bitmap, 16'h0020); end
        checks++; if (top_tskid !== 4'd5) begin failures++; $display("[TB] FAIL rmv3_top: got %0d expected 5", top_tskid); end
        checks++; if (top_valid !== 1'b1) begin failures++; $display("[TB] FAIL rmv3_valid: got %b expected 1", top_valid); end
        rdq_rmv = 16'h0020;
        tick();
        rdq_rmv = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0000) begin failures++; $display("[TB] FAIL rmv5_bitmap: got %h expected %h", rdy_bitmap, 16'h0000); end
        checks++; if (top_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmv5_valid: got %b expected 0", top_valid); end
        checks++; if (top_tskid !== 4'd5) begin failures++; $display("[TB] FAIL rmv5_hold_id: got %0d expected 5", top_tskid); end
        // Removing a task that is not ready changes nothing.
        rdq_rmv = 16'h0001;
        tick();
        rdq_rmv = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0000) begin failures++; $display("[TB] FAIL rmv_noop_bitmap: got %h expected %h", rdy_bitmap, 16'h0000); end
        checks++; if (top_tskid !== 4'd5) begin failures++; $display("[TB] FAIL rmv_noop_id: got %0d expected 5", top_tskid); end
    endtask

    task automatic test_add_rmv_same();
        rdq_add = 16'h0080;
        tick();
        rdq_add = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0080) begin failures++; $display("[TB] FAIL same_setup_bitmap: got %h expected %h", rdy_bitmap, 16'h0080); end
        // Add a task that is already ready: it is acknowledged and the bitmap stays the same.
        rdq_add = 16'h0080;
        #1;
        checks++; if (rdy_tsk !== 16'h0080) begin failures++; $display("[TB] FAIL same_readd_ack: got %h expected %h", rdy_tsk, 16'h0080); end
        tick();
        rdq_add = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0080) begin failures++; $display("[TB] FAIL same_readd_bitmap: got %h expected %h", rdy_bitmap, 16'h0080); end
        // Add and remove on the same task: the remove wins and the add stays pending.
        rdq_add = 16'h0080;
        rdq_rmv = 16'h0080;
        #1;
        checks++; if (rdy_tsk !== 16'h0000) begin failures++; $display("[TB] FAIL same_no_ack: got %h expected %h", rdy_tsk, 16'h0000); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL same_busy: got %b expected 1", busy); end
        tick();
        rdq_rmv = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0000) begin failures++; $display("[TB] FAIL same_cleared: got %h expected %h", rdy_bitmap, 16'h0000); end
        checks++; if (top_valid !== 1'b0) begin failures++; $display("[TB] FAIL same_cleared_valid: got %b expected 0", top_valid); end
        checks++; if (rdy_tsk !== 16'h0080) begin failures++; $display("[TB] FAIL same_late_ack: got %h expected %h", rdy_tsk, 16'h0080); end
        tick();
        rdq_add = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0080) begin failures++; $display("[TB] FAIL same_readded: got %h expected %h", rdy_bitmap, 16'h0080); end
        checks++; if (top_tskid !== 4'd7) begin failures++; $display("[TB] FAIL same_readded_top: got %0d expected 7", top_tskid); end
        rdq_rmv = 16'h0080;
        tick();
        rdq_rmv = '0;
    endtask

    task automatic test_priority();
        rdq_add = 16'h0044;
        tick();
        rdq_add = 16'h0040;
        tick();
        rdq_add = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0044) begin failures++; $display("[TB] FAIL pri_setup_bitmap: got %h expected %h", rdy_bitmap, 16'h0044); end
        checks++; if (top_tskid !== 4'd2) begin failures++; $display("[TB] FAIL pri_setup_top: got %0d expected 2", top_tskid); end
        set_pri(6, 4'd1);
        #1;
        checks++; if (top_tskid !== 4'd2) begin failures++; $display("[TB] FAIL pri_registered: got %0d expected 2", top_tskid); end
        tick();
        checks++; if (top_tskid !== 4'd6) begin failures++; $display("[TB] FAIL pri_change_top: got %0d expected 6", top_tskid); end
        set_pri(2, 4'd1);
        tick();
        checks++; if (top_tskid !== 4'd2) begin failures++; $display("[TB] FAIL pri_tie_top: got %0d expected 2", top_tskid); end
        set_pri(2, 4'd2);
        set_pri(6, 4'd6);
        rdq_rmv = 16'h0044;
        tick();
        rdq_rmv = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0000) begin failures++; $display("[TB] FAIL pri_cleanup: got %h expected %h", rdy_bitmap, 16'h0000); end
    endtask

    task automatic test_cke();
        rdq_add = 16'h0010;
        cke     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rdy_tsk !== 16'h0000) begin failures++; $display("[TB] FAIL cke_no_ack[%0d]: got %h expected %h", c, rdy_tsk, 16'h0000); end
            checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL cke_busy[%0d]: got %b expected 1", c, busy); end
            checks++; if (rdy_bitmap !== 16'h0000) begin failures++; $display("[TB] FAIL cke_hold[%0d]: got %h expected %h", c, rdy_bitmap, 16'h0000); end
            tick();
        end
        cke = 1'b1;
        #1;
        checks++; if (rdy_tsk !== 16'h0010) begin failures++; $display("[TB] FAIL cke_ack: got %h expected %h", rdy_tsk, 16'h0010); end
        tick();
        rdq_add = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0010) begin failures++; $display("[TB] FAIL cke_bitmap: got %h expected %h", rdy_bitmap, 16'h0010); end
        checks++; if (top_tskid !== 4'd4) begin failures++; $display("[TB] FAIL cke_top: got %0d expected 4", top_tskid); end
    endtask

    task automatic test_reset_mid();
        rdq_add = 16'h0002;
        reset   = 1'b1;
        #1;
        checks++; if (rdy_tsk !== 16'h0000) begin failures++; $display("[TB] FAIL rst_mid_no_ack: got %h expected %h", rdy_tsk, 16'h0000); end
        tick();
        checks++; if (rdy_bitmap !== 16'h0000) begin failures++; $display("[TB] FAIL rst_mid_bitmap: got %h expected %h", rdy_bitmap, 16'h0000); end
        checks++; if (top_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", top_valid); end
        checks++; if (top_tskid !== 4'd0) begin failures++; $display("[TB] FAIL rst_mid_id: got %0d expected 0", top_tskid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_busy: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (rdy_tsk !== 16'h0002) begin failures++; $display("[TB] FAIL rst_after_ack: got %h expected %h", rdy_tsk, 16'h0002); end
        tick();
        rdq_add = '0;
        #1;
        checks++; if (rdy_bitmap !== 16'h0002) begin failures++; $display("[TB] FAIL rst_after_bitmap: got %h expected %h", rdy_bitmap, 16'h0002); end
        checks++; if (top_tskid !== 4'd1) begin failures++; $display("[TB] FAIL rst_after_top: got %0d expected 1", top_tskid); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_remove();
        test_add_rmv_same();
        test_priority();
        test_cke();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jelly_rtos_ready_queue.md
Name: jelly_rtos_ready_queue

Overview:
- Central ready-queue stage that sits directly downstream of the per-task state blocks.
- Collects their rdq_add/rdq_rmv requests, acknowledges each accepted add with a one-hot rdy_tsk pulse, and keeps a ready bitmap.
- Publishes the highest-priority ready task as top_tskid, registered.
- The dispatcher feeds top_tskid back to every task block as run_tskid.

Parameters:
- TASKS, 16, number of task blocks served (≥2).
- TSKID_WIDTH, 4, task ID width; 2**TSKID_WIDTH ≥ TASKS.
- TSKPRI_WIDTH, 4, priority width; a numerically lower value means a higher priority.
- INIT_READY, '0, TASKS-bit ready bitmap loaded at reset.

Ports:
- reset  in  1  synchronous, active-high reset.
- clk  in  1  clock.
- cke  in  1  clock enable; when low, all state holds and rdy_tsk is forced to 0.
- busy  out  1  high while any rdq_add bit is pending and not yet acknowledged.
- rdq_add  in  TASKS  per-task level request: add to ready queue; held until acknowledged.
- rdq_rmv  in  TASKS  per-task single-cycle request: remove from ready queue.
- tskpri  in  TASKS*TSKPRI_WIDTH  packed per-task priority; task i occupies bits [i*TSKPRI_WIDTH +: TSKPRI_WIDTH].
- rdy_tsk  out  TASKS  combinational one-hot acknowledge of the add accepted this cycle.
- rdy_bitmap  out  TASKS  registered ready bitmap.
- top_valid  out  1  registered; at least one task is ready.
- top_tskid  out  TSKID_WIDTH  registered ID of the highest-priority ready task.

Behaviour:
- Reset values:
  - rdy_bitmap = INIT_READY.
  - top_valid and top_tskid = the selection computed over INIT_READY; if INIT_READY is 0, top_valid = 0 and top_tskid = 0.
  - rdy_tsk = 0.
  - busy follows rdq_add combinationally (busy = |rdq_add, independent of reset).
- Add arbitration:
  - At most one add is accepted per cycle: the lowest index i with rdq_add[i]=1 and rdq_rmv[i]=0.
  - rdy_tsk[i]=1 in that same cycle (combinational, gated by cke). The task clears its rdq_add on that edge, so no add is ever acknowledged twice.
  - On the edge, rdy_bitmap[i] <= 1.
- Add to an already-ready task: still acknowledged; bitmap unchanged.
- Remove:
  - Every bit with rdq_rmv[i]=1 is cleared on the edge; multiple removes per cycle are allowed.
  - Removing a task that is not ready is a no-op.
- Simultaneous add and remove on the same task: remove wins. The add is not acknowledged and stays pending; it is accepted in a later cycle once rdq_rmv is low.
- Simultaneous add on task i and remove on task j≠i: both take effect on the same edge.
- Selection (1-cycle latency):
  - Computed over the next-state bitmap and registered, so top_* reflect the bitmap that rdy_bitmap holds in the same cycle.
  - Winner = ready task with the minimum tskpri. Ties go to the lowest task ID.
  - Implemented as a balanced comparator tree over TASKS entries; tree depth is a timing concern only, with no extra latency.
  - With no ready task: top_valid=0 and top_tskid holds its previous value.
- Priority change:
  - tskpri is sampled every cycle. A change re-evaluates the selection on the next edge even with no add or remove.
- cke low:
  - Bitmap and top_* hold; no acknowledge is issued.
  - Pending adds remain pending and busy stays high.
- Reset mid-operation:
  - Pending adds are not acknowledged during reset.
  - Tasks keep rdq_add high and are accepted in order after reset deasserts.
- Ports for a task index ≥ TASKS are never driven.

Test Plan:
- Reset with INIT_READY=0, then rdq_add[5]=1 with tskpri[5]=5 → rdy_tsk=16'h0020 in that cycle; next cycle rdy_bitmap=16'h0020, top_valid=1, top_tskid=5.
- rdq_add[3] and rdq_add[9] both high from cycle 0 (tskpri = ID) → cycle 0 ack task 3, cycle 1 ack task 9; busy=1 for exactly 2 cycles. After cycle 1, top_tskid=3, and top_tskid=3 holds after task 9 joins.
- Tasks 3 and 5 ready, single-cycle rdq_rmv[3] → next cycle top_tskid=5, bitmap=16'h0020. Then rdq_rmv[5] → top_valid=0, top_tskid stays 5.
- Same cycle rdq_add[7]=1 and rdq_rmv[7]=1 with task 7 ready → no ack, bit 7 cleared. Next cycle the add is acked and bit 7 is set again.
- Tasks 2 and 6 ready; change tskpri[6] from 6 to 1 → one cycle later top_tskid=6. Set tskpri[2]=1 to create a tie → top_tskid=2.
- rdq_add[4] high with cke=0 for 3 cycles → rdy_tsk=0, busy=1, bitmap unchanged. cke=1 → ack task 4 that cycle. Assert reset with rdq_add[1] held → no ack during reset, ack on the first cycle after reset.
